// File: rtl/sprite_comp_select.sv
// Sprite compositor select stage: a small sprite table, a registered
// per-slot hit vector captured on the compare strobe, and a priority pick
// of the lowest-index hit colour on the select strobe.
module sprite_comp_select #(
   parameter int                 N_SPR    = 4,
   parameter int                 SPR_SIZE = 16,
   parameter int                 COLOR_W  = 9,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               refresh_comp,
   input  logic               refresh_select,
   input  logic [9:0]         pixel_x,
   input  logic [9:0]         pixel_y,
   input  logic               wr_en,
   input  logic [2:0]         wr_addr,
   input  logic [9:0]         wr_x,
   input  logic [9:0]         wr_y,
   input  logic [COLOR_W-1:0] wr_color,
   input  logic               wr_active,
   output logic               is_pixel,
   output logic [COLOR_W-1:0] color_out,
   output logic               color_valid,
   output logic               seq_err
);

   // 11-bit span so a sprite placed near column/row 1023 never wraps to 0
   localparam logic [10:0] SPAN = 11'(SPR_SIZE);

   typedef enum logic [1:0] {ST_IDLE, ST_HIT, ST_SEL} state_t;

   logic [N_SPR-1:0]   hit_now;
   logic [COLOR_W-1:0] spr_color [N_SPR];

   genvar gi;
   generate
      for (gi = 0; gi < N_SPR; gi++) begin : g_slot
         logic [9:0]         x_q, x_d, y_q, y_d;
         logic [COLOR_W-1:0] color_q, color_d;
         logic               active_q, active_d;
         logic               wr_sel;

         // slot indices past N_SPR simply match no slot
         assign wr_sel = wr_en && (wr_addr == 3'(gi));

         // next table contents for this slot
         always_comb begin
            x_d      = x_q;
            y_d      = y_q;
            color_d  = color_q;
            active_d = active_q;
            if (wr_sel) begin
               x_d      = wr_x;
               y_d      = wr_y;
               color_d  = wr_color;
               active_d = wr_active;
            end
         end

         // table storage; only the enable bit is cleared by reset
         always_ff @(posedge clk) begin
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            if (!reset) begin
               active_q <= 1'b0;
            end else begin
               active_q <= active_d;
            end
         end

         // hit test against the pre-write table contents
         assign hit_now[gi] = active_q
            && ({1'b0, pixel_x} >= {1'b0, x_q}) && ({1'b0, pixel_x} < ({1'b0, x_q} + SPAN))
            && ({1'b0, pixel_y} >= {1'b0, y_q}) && ({1'b0, pixel_y} < ({1'b0, y_q} + SPAN));

         assign spr_color[gi] = color_q;
      end
   endgenerate

   state_t             state_q, state_d;
   logic [N_SPR-1:0]   hit_q, hit_d;
   logic [COLOR_W-1:0] color_out_q, color_out_d;
   logic               color_valid_q, color_valid_d;
   logic               seq_err_q, seq_err_d;
   logic               is_pixel_q, is_pixel_d;
   logic [COLOR_W-1:0] sel_color;

   // lowest-index hit slot wins, background if nothing was hit
   always_comb begin
      sel_color = BG_COLOR;
      for (int i = N_SPR - 1; i >= 0; i--) begin
         if (hit_q[i]) begin
            sel_color = spr_color[i];
         end
      end
   end

   // sequencing: compare always wins; select is only legal while a hit is pending
   always_comb begin
      state_d       = state_q;
      hit_d         = hit_q;
      color_out_d   = color_out_q;
      color_valid_d = 1'b0;
      seq_err_d     = seq_err_q;
      is_pixel_d    = (pixel_x < 10'd640) && (pixel_y < 10'd480);
      if (refresh_comp) begin
         hit_d   = hit_now;
         state_d = ST_HIT;
         if (refresh_select) begin
            seq_err_d = 1'b1;
         end
      end else begin
         // SEL is a one-cycle state; a stray select there still drops to IDLE
         if (state_q == ST_SEL) begin
            state_d = ST_IDLE;
         end
         if (refresh_select) begin
            if (state_q == ST_HIT) begin
               color_out_d   = sel_color;
               color_valid_d = 1'b1;
               state_d       = ST_SEL;
            end else begin
               seq_err_d = 1'b1;
            end
         end
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         hit_q         <= '0;
         color_out_q   <= BG_COLOR;
         color_valid_q <= 1'b0;
         seq_err_q     <= 1'b0;
         is_pixel_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         hit_q         <= hit_d;
         color_out_q   <= color_out_d;
         color_valid_q <= color_valid_d;
         seq_err_q     <= seq_err_d;
         is_pixel_q    <= is_pixel_d;
      end
   end

   assign is_pixel    = is_pixel_q;
   assign color_out   = color_out_q;
   assign color_valid = color_valid_q;
   assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_sprite_comp_select.sv
// Scoreboard bench for sprite_comp_select: directed scenarios followed by
// randomized strobes and table writes, checked against a rule-level model.
module tb_sprite_comp_select;
   localparam int            N  = 4;
   localparam int            SZ = 16;
   localparam int            CW = 9;
   localparam logic [CW-1:0] BG = '0;

   logic          clk;
   logic          reset;
   logic          refresh_comp, refresh_select;
   logic [9:0]    pixel_x, pixel_y;
   logic          wr_en;
   logic [2:0]    wr_addr;
   logic [9:0]    wr_x, wr_y;
   logic [CW-1:0] wr_color;
   logic          wr_active;
   logic          is_pixel;
   logic [CW-1:0] color_out;
   logic          color_valid;
   logic          seq_err;

   sprite_comp_select #(
      .N_SPR(N), .SPR_SIZE(SZ), .COLOR_W(CW), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .reset(reset),
      .refresh_comp(refresh_comp), .refresh_select(refresh_select),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
      .wr_color(wr_color), .wr_active(wr_active),
      .is_pixel(is_pixel), .color_out(color_out),
      .color_valid(color_valid), .seq_err(seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: sprite table, captured hit set, "compare pending" flag
   int            m_x [N];
   int            m_y [N];
   logic [CW-1:0] m_c [N];
   bit            m_act [N];
   bit [N-1:0]    m_hit;
   bit            armed;

   // per-edge expectations, consumed by the monitor
   bit            mon_en, e_rst, e_seq, e_ispix, e_valid;
   logic [CW-1:0] exp_q [$];
   logic [CW-1:0] cur_color;
   int            checks, errors;

   function automatic bit [N-1:0] geo_hits(input int px, input int py);
      bit [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         r[i] = m_act[i] && px >= m_x[i] && px < m_x[i] + SZ
                         && py >= m_y[i] && py < m_y[i] + SZ;
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] pick(input bit [N-1:0] h);
      for (int i = 0; i < N; i++) begin
         if (h[i]) return m_c[i];
      end
      return BG;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // one clock of stimulus plus the model's view of that clock
   task automatic cyc(input bit rn, input bit cp, input bit sl, input int px, input int py,
                      input bit we, input int wa, input int wx, input int wy, input int wc,
                      input bit wact);
      @(negedge clk);
      reset = rn; refresh_comp = cp; refresh_select = sl;
      pixel_x = 10'(px); pixel_y = 10'(py);
      wr_en = we; wr_addr = 3'(wa); wr_x = 10'(wx); wr_y = 10'(wy);
      wr_color = CW'(wc); wr_active = wact;
      e_valid = 0;
      if (!rn) begin
         e_rst = 1; e_seq = 0; e_ispix = 0; armed = 0; m_hit = '0;
      end else begin
         e_rst = 0;
         e_ispix = (px < 640) && (py < 480);
         if (cp) begin
            m_hit = geo_hits(px, py);
            armed = 1;
            if (sl) e_seq = 1;
         end else if (sl) begin
            if (armed) begin
               exp_q.push_back(pick(m_hit));
               e_valid = 1;
               armed = 0;
            end else begin
               e_seq = 1;
            end
         end
      end
      mon_en = 1;
      $display("cyc t=%0t rst_n=%0d comp=%0d sel=%0d px=%0d py=%0d we=%0d wa=%0d", $time, rn, cp, sl, px, py, we, wa);
      @(posedge clk);
      if (we && wa < N) begin
         m_x[wa] = wx; m_y[wa] = wy; m_c[wa] = CW'(wc); m_act[wa] = wact;
      end
      if (!rn) begin
         for (int i = 0; i < N; i++) m_act[i] = 0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic rst();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic wr(input int a, input int x, input int y, input int c, input bit act);
      cyc(1, 0, 0, 0, 0, 1, a, x, y, c, act);
   endtask
   task automatic comp(input int px, input int py);
      cyc(1, 1, 0, px, py, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic sel();
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic pix(input int px, input int py);
      cyc(1, 0, 0, px, py, 0, 0, 0, 0, 0, 0);
   endtask

   // monitor: compares registered outputs just after each rising edge
   initial begin
      cur_color = BG;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            chk("is_pixel", int'(is_pixel), int'(e_ispix));
            chk("seq_err", int'(seq_err), int'(e_seq));
            chk("color_valid", int'(color_valid), int'(e_valid));
            if (e_rst) cur_color = BG;
            if (color_valid) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL scoreboard at %0t: color_valid with no expected entry, got 0x%0h", $time, color_out);
               end else begin
                  cur_color = exp_q.pop_front();
               end
            end
            chk("color_out", int'(color_out), int'(cur_color));
         end
      end
   end

   initial begin
      int px, py;
      checks = 0; errors = 0; mon_en = 0; armed = 0; m_hit = '0;
      e_rst = 1; e_seq = 0; e_ispix = 0; e_valid = 0;
      for (int i = 0; i < N; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_c[i] = '0; m_act[i] = 0;
      end
      reset = 0; refresh_comp = 0; refresh_select = 0; pixel_x = '0; pixel_y = '0;
      wr_en = 0; wr_addr = '0; wr_x = '0; wr_y = '0; wr_color = '0; wr_active = 0;

      rst(); rst(); idle(1);
      // select without a prior compare: sticky error, background colour held
      sel(); idle(2); sel(); idle(1);
      rst();
      // single sprite, compare then select two cycles later
      wr(0, 100, 100, 'h1AA, 1); comp(105, 110); idle(1); sel(); idle(2);
      // overlap priority, then the lower slot disabled
      wr(0, 200, 200, 'h011, 1); wr(2, 195, 195, 'h022, 1);
      comp(200, 200); idle(1); sel();
      wr(0, 200, 200, 'h011, 0); comp(200, 200); idle(1); sel(); idle(1);
      // sprite edge pixels
      wr(1, 50, 50, 'h0F0, 1);
      comp(64, 64); idle(1); sel();
      comp(65, 65); idle(1); sel();
      comp(66, 66); idle(1); sel();
      comp(49, 50); idle(1); sel();
      // out-of-range slot write is ignored
      wr(5, 49, 50, 'h1FF, 1); comp(49, 50); idle(1); sel();
      // simultaneous strobes, then a valid select
      cyc(1, 1, 1, 60, 60, 0, 0, 0, 0, 0, 0); idle(1); sel(); idle(1);
      rst(); idle(1);
      // visible-area limits and right/bottom edge sprite
      pix(639, 479); pix(640, 479); pix(639, 480); pix(1023, 0);
      wr(3, 1020, 1020, 'h155, 1); comp(1023, 1023); sel();
      comp(1019, 1023); sel();
      // compare in the same cycle as a write uses the old table
      cyc(1, 1, 0, 1023, 1023, 1, 3, 0, 0, 'h077, 1); sel();
      // back-to-back compare/select with two-cycle spacing
      for (int k = 0; k < 4; k++) begin
         comp(1020 + k, 1021); idle(1); sel();
      end
      // held strobes: compare re-latches, second select is an error
      comp(5, 5); comp(1021, 1022); sel(); sel(); idle(1);
      rst(); idle(1);

      // randomized phase
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 3) == 0) begin
            px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
         end else begin
            px = $urandom_range(0, 63); py = $urandom_range(0, 63);
         end
         if (r == 0) begin
            rst();
         end else begin
            cyc(1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, px, py,
                $urandom_range(0, 4) == 0, $urandom_range(0, 7),
                $urandom_range(0, 56), $urandom_range(0, 56), $urandom_range(0, 511),
                $urandom_range(0, 3) != 0);
         end
      end
      idle(3);
      mon_en = 0;
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
